// File: rtl/mem_io_responder.sv
// mem_io_responder: bus responder (RAM, LED register, switch register) with a sticky error flag.
// Define MEM_WAIT_STATE_EN to stretch BUSY to WAIT_CYCLES cycles; otherwise BUSY lasts one cycle.
module mem_io_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int RAM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR = 9'h140,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [1:0] MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10, MILL = 2'b11;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
`ifdef MEM_WAIT_STATE_EN
  localparam logic [CW-1:0] LOAD = CW'(WAIT_CYCLES - 1);
`else
  localparam logic [CW-1:0] LOAD = '0;
`endif
  state_t state_q, state_d;
  logic [1:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rd_val;
  logic [7:0] sw_q, sw_d, led_q, led_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, err_q, err_d;
  logic is_ram, is_led, is_sw, rd_ok, wr_ram, wr_led, acc_err;
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  always_comb begin
    is_ram = 32'(addr_q) < RAM_DEPTH;
    is_led = addr_q == LED_ADDR;
    is_sw = addr_q == SW_ADDR;
    rd_ok = cmd_q == MREAD && (is_ram || is_led || is_sw);
    wr_ram = cmd_q == MWRITE && is_ram;
    wr_led = cmd_q == MWRITE && is_led;
    acc_err = cmd_q == MILL || (cmd_q == MREAD && !rd_ok) || (cmd_q == MWRITE && !(is_ram || is_led));
    rd_val = is_ram ? mem[addr_q[AW-1:0]] : {{(DATA_W-8){1'b0}}, is_led ? led_q : sw_q};
  end
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    sw_d = sw_q;
    cnt_d = cnt_q;
    led_d = led_q;
    err_d = err_q;
    ready_d = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: if (mem_cmd != MNONE) begin
        cmd_d = mem_cmd;
        addr_d = mem_addr;
        wdata_d = write_data;
        sw_d = sw;
        cnt_d = LOAD;
        state_d = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        state_d = RESP;
        ready_d = 1'b1;
        rdata_d = rd_ok ? rd_val : '0;
        err_d = err_q | acc_err;
      end else cnt_d = cnt_q - 1'b1;
      RESP: begin
        state_d = IDLE;
        led_d = wr_led ? wdata_q[7:0] : led_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q <= MNONE;
      addr_q <= '0;
      wdata_q <= '0;
      sw_q <= '0;
      cnt_q <= '0;
      led_q <= '0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      sw_q <= sw_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
      err_q <= err_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end
  // RAM is not reset; a reset edge suppresses the pending store
  always_ff @(posedge clk)
    if (reset && state_q == RESP && wr_ram) mem[addr_q[AW-1:0]] <= wdata_q;
  assign read_data = rdata_q;
  assign mem_ready = ready_q;
  assign led = led_q;
  assign bus_err = err_q;
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter DATA_W, 16: bus data width.
REQ-002 Parameter ADDR_W, 9: bus address width.
REQ-003 Parameter RAM_DEPTH, 256: RAM words, mapped at addresses 0..RAM_DEPTH-1.
REQ-004 Parameter LED_ADDR, 9'h100: LED output register address.
REQ-005 Parameter SW_ADDR, 9'h140: switch input register address.
REQ-006 Parameter WAIT_CYCLES, 2: wait states per access when the wait-state feature is compiled in (1..15).
REQ-007 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-008 Port reset, input, 1: synchronous, active-low reset.
REQ-009 Port mem_cmd, input, 2: 00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal.
REQ-010 Port mem_addr, input, ADDR_W: access address.
REQ-011 Port write_data, input, DATA_W: store data.
REQ-012 Port read_data, output, DATA_W: load data, valid only while mem_ready=1.
REQ-013 Port mem_ready, output, 1: one-cycle completion strobe.
REQ-014 Port sw, input, 8: switch levels.
REQ-015 Port led, output, 8: LED register contents.
REQ-016 Port bus_err, output, 1: sticky error flag.

Function
REQ-017 The FSM SHALL use three states: IDLE, BUSY and RESP.
REQ-018 In IDLE, mem_cmd != MNONE SHALL latch cmd, addr and write_data and move to BUSY; bus inputs are ignored outside IDLE.
REQ-019 BUSY SHALL load a down-counter and advance to RESP when it reaches zero (see Configuration).
REQ-020 RESP SHALL assert mem_ready for exactly one cycle, then return to IDLE.
REQ-021 The initiator drops mem_cmd in the mem_ready cycle; a command still present in IDLE after RESP SHALL be treated as a new transaction.
REQ-022 A read of addr < RAM_DEPTH SHALL return the RAM word in RESP.
REQ-023 A read of SW_ADDR SHALL return {8'h00, sw}, sampled at latch time.
REQ-024 A read of LED_ADDR SHALL return {8'h00, led}.
REQ-025 A read of any other address SHALL return 16'h0000 and set bus_err.
REQ-026 A write of addr < RAM_DEPTH SHALL update RAM in the RESP cycle.
REQ-027 A write of LED_ADDR SHALL load led <= write_data[7:0] in the RESP cycle.
REQ-028 A write of SW_ADDR or of an unmapped address SHALL change no storage and SHALL set bus_err.
REQ-029 An illegal cmd (11) SHALL complete normally, with read_data 0, no storage change, and bus_err set.
REQ-030 read_data SHALL be 16'h0000 whenever mem_ready=0.
REQ-031 bus_err SHALL stay set until reset.

Reset
REQ-032 With reset=0 at a rising edge, the block SHALL set state=IDLE, mem_ready=0, read_data=0, led=0, bus_err=0, and clear the counter.
REQ-033 Reset SHALL abort any in-flight transaction with no RAM or LED update and no mem_ready pulse.
REQ-034 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-035 With MEM_WAIT_STATE_EN defined, BUSY SHALL last WAIT_CYCLES cycles, so mem_ready rises WAIT_CYCLES+1 cycles after the command is accepted.
REQ-036 Without MEM_WAIT_STATE_EN, BUSY SHALL last exactly one cycle, so mem_ready rises 2 cycles after acceptance.

Verification
REQ-037 Write 16'hFFE9 to addr 25, then read addr 25 -> read_data=16'hFFE9 with mem_ready; latency is 2 cycles, or 3 with the macro and WAIT_CYCLES=2.
REQ-038 sw=8'hA5, read SW_ADDR -> 16'h00A5; write 16'h1234 to LED_ADDR -> led=8'h34, bus_err=0.
REQ-039 Read addr 9'h1FF; write SW_ADDR -> read_data=0, bus_err=1, held until reset, sw register unchanged.
REQ-040 Assert reset in BUSY of a write to addr 3 (old value 16'h0007) -> no mem_ready, mem[3]=16'h0007, led=0, state=IDLE.
REQ-041 Hold MREAD of addr 0 for 10 cycles -> back-to-back transactions, one mem_ready per transaction, none in consecutive cycles.
REQ-042 Issue cmd=11 -> single mem_ready, read_data=0, bus_err=1, RAM and led unchanged.
